// File: rtl/instr_encoder.sv
// Symbolic command -> RV32I machine word encoder that fills instruction memory sequentially.
// LI is expanded to LUI and/or ADDI; the second word is issued from the LI2 state.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_kind,
   input  logic [2:0]        cmd_funct3,
   input  logic              cmd_f7b5,
   input  logic [4:0]        cmd_rd,
   input  logic [4:0]        cmd_rs1,
   input  logic [4:0]        cmd_rs2,
   input  logic [31:0]       cmd_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err_illegal,
   output logic              err_overflow
);

   typedef enum logic {IDLE, LI2} state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wptr_q, wptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_ill_q, err_ill_d;
   logic                err_ovf_q, err_ovf_d;
   logic [31:0]         pend_q, pend_d;

   logic                full_w;
   logic                accept;
   logic                legal;
   logic                li_two;
   logic [31:0]         word;
   logic [31:0]         li_second;
   logic [19:0]         li_up;
   logic                do_emit;
   logic [31:0]         emit_word;

   assign full_w    = (count_q == DEPTH_C);
   assign cmd_ready = (state_q == IDLE) && !full_w;
   assign accept    = cmd_valid && cmd_ready;

   // (imm + 0x800)[31:12] equals imm[31:12] plus the carry out of the low 12 bits, which is imm[11]
   assign li_up = cmd_imm[31:12] + {19'd0, cmd_imm[11]};

   always_comb begin
      legal     = 1'b1;
      li_two    = 1'b0;
      word      = 32'd0;
      li_second = {cmd_imm[11:0], cmd_rd, 3'b000, cmd_rd, OP_I};
      case (cmd_kind)
         4'd0: word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_LOAD};
         4'd1: word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, cmd_funct3, cmd_imm[4:0], OP_STORE};
         4'd2: word = {1'b0, cmd_f7b5, 5'b00000, cmd_rs2, cmd_rs1, cmd_funct3, cmd_rd, OP_R};
         4'd3: word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, cmd_funct3,
                       cmd_imm[4:1], cmd_imm[11], OP_BRANCH};
         4'd4: begin
            if (cmd_funct3 == 3'b001 || cmd_funct3 == 3'b101)
               word = {1'b0, cmd_f7b5, 5'b00000, cmd_imm[4:0], cmd_rs1, cmd_funct3, cmd_rd, OP_I};
            else
               word = {cmd_imm[11:0], cmd_rs1, cmd_funct3, cmd_rd, OP_I};
         end
         4'd5: word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, OP_JAL};
         4'd6: word = {cmd_imm[11:0], cmd_rs1, 3'b000, cmd_rd, OP_JALR};
         4'd7: word = {cmd_imm[31:12], cmd_rd, OP_AUIPC};
         4'd8: word = {cmd_imm[31:12], cmd_rd, OP_LUI};
         4'd9: begin
            // Fits a signed 12-bit immediate when bits 31..11 are all equal
            if (cmd_imm[31:11] == '0 || cmd_imm[31:11] == '1) begin
               word = {cmd_imm[11:0], 5'd0, 3'b000, cmd_rd, OP_I};
            end else begin
               word   = {li_up, cmd_rd, OP_LUI};
               li_two = (cmd_imm[11:0] != 12'd0);
            end
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      count_d   = count_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_ill_d = err_ill_q;
      err_ovf_d = err_ovf_q;
      pend_d    = pend_q;
      do_emit   = 1'b0;
      emit_word = word;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (legal) begin
                  do_emit = 1'b1;
                  if (li_two) begin
                     state_d = LI2;
                     pend_d  = li_second;
                  end
               end else begin
                  err_ill_d = 1'b1;
               end
            end
         end
         LI2: begin
            state_d = IDLE;
            if (full_w) begin
               err_ovf_d = 1'b1;
            end else begin
               do_emit   = 1'b1;
               emit_word = pend_q;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_emit) begin
         we_d    = 1'b1;
         wdata_d = emit_word;
         addr_d  = wptr_q;
         wptr_d  = wptr_q + ADDR_W'(1);
         count_d = count_q + (ADDR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wptr_q    <= BASE_C;
         count_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= BASE_C;
         wdata_q   <= 32'd0;
         err_ill_q <= 1'b0;
         err_ovf_q <= 1'b0;
         pend_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         wptr_q    <= wptr_d;
         count_q   <= count_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_ill_q <= err_ill_d;
         err_ovf_q <= err_ovf_d;
         pend_q    <= pend_d;
      end
   end

   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign count        = count_q;
   assign full         = full_w;
   assign err_illegal  = err_ill_q;
   assign err_overflow = err_ovf_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Converts a stream of symbolic instruction commands into 32-bit RV32I machine words and writes them sequentially into instruction memory.
- It is the writer side of the control decode path: it produces exactly the opcode classes the main decoder consumes (load, store, R-type, branch, I-type, JAL, JALR, AUIPC, LUI).
- It also expands an LI pseudo-op into LUI and/or ADDI.
- Used by program loaders and self-checking benches to fill instruction memory before the pipeline runs.

Parameters:
ADDR_W, 8, width of word address into instruction memory
BASE_ADDR, 0, first word address written after reset
DEPTH, 256, maximum number of words written before full (must be <= 2^ADDR_W)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_kind  input  4  0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6 JALR, 7 AUIPC, 8 LUI, 9 LI; 10-15 illegal
cmd_funct3  input  3  funct3 field; ignored for JAL, JALR, AUIPC, LUI, LI
cmd_f7b5  input  1  funct7 bit 5, used for RTYPE and for ITYPE shifts
cmd_rd  input  5  destination register
cmd_rs1  input  5  source register 1
cmd_rs2  input  5  source register 2
cmd_imm  input  32  immediate (byte offset for BRANCH/JAL; full value for LUI/AUIPC/LI)
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written since reset
full  output  1  count == DEPTH
err_illegal  output  1  sticky; set when an illegal cmd_kind is accepted
err_overflow  output  1  sticky; set when an LI second word is dropped because the block is full

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0
  - count=0, full=0, err_illegal=0, err_overflow=0
  - state=IDLE
- Reset mid-LI returns to IDLE; the pending second word is never written.
- Handshake:
  - cmd_ready = (state==IDLE) && !full.
  - A command is accepted when cmd_valid && cmd_ready are both high at a clk edge.
- Latency and write pointer:
  - The encoded word appears with mem_we=1 on the cycle after acceptance (registered outputs).
  - mem_we is a one-cycle pulse per word.
  - mem_addr holds the address of the word currently being written.
  - The internal write pointer increments after each write and wraps modulo 2^ADDR_W.
  - count increments per word.
- Encodings (opcodes: LOAD 0000011, STORE 0100011, R 0110011, BRANCH 1100011, I 0010011, JAL 1101111, JALR 1100111, AUIPC 0010111, LUI 0110111):
  - LOAD: {imm[11:0], rs1, f3, rd, op}
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - RTYPE: {0,f7b5,00000, rs2, rs1, f3, rd, op}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; imm[0] ignored
  - ITYPE:
    - f3=001 or 101: {0,f7b5,00000, imm[4:0], rs1, f3, rd, op}
    - otherwise: {imm[11:0], rs1, f3, rd, op}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - JALR: {imm[11:0], rs1, 000, rd, op}
  - AUIPC and LUI: {imm[31:12], rd, op}
- LI expansion:
  - If imm is in the range -2048..2047: one word, ADDI rd,x0,imm[11:0].
  - Otherwise up = (imm + 0x800)[31:12], and the block emits LUI rd,up.
  - If imm[11:0] != 0, the block then enters state LI2 and emits ADDI rd,rd,imm[11:0] on the next cycle.
  - cmd_ready is 0 during LI2.
  - LI2 always returns to IDLE.
- States: IDLE (accept and emit first word) and LI2 (emit second word, then IDLE).
- Illegal kind:
  - The command is accepted and err_illegal is set.
  - No write occurs and count is unchanged.
- Full:
  - Once count==DEPTH, full=1 and cmd_ready=0 until reset.
  - If full is reached after an LI first word, the LI2 word is dropped, err_overflow is set, and the state returns to IDLE.
- Arithmetic:
  - The LI immediate add is 32-bit and wraps (imm=0x7FFFF800 → up=0x80000).
  - Upper bits of cmd_imm that are unused by an encoding are ignored, with no range error.

Test Plan:
- After reset, ITYPE f3=000 rd=1 rs1=0 imm=5 → one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00500093, count=1.
- STORE f3=010 rs1=1 rs2=2 imm=8, then BRANCH f3=000 rs1=1 rs2=2 imm=-4, back-to-back → 0x0020A423 at addr 0, 0xFE208EE3 at addr 1; cmd_ready stays 1 throughout.
- LI rd=5 imm=0x12345678 → 0x123452B7 at addr 0, 0x67828293 at addr 1; cmd_ready=0 for one cycle. LI rd=4 imm=0x1800 → 0x00002237, 0x80020213.
- LI rd=3 imm=-1 → single word 0xFFF00193. LI rd=6 imm=0x10000 → single word 0x00010337. LUI rd=2 imm=0x12345000 → 0x12345137.
- DEPTH=4: issue 3 ITYPE commands, then LI imm=0x12345678 → LUI written at addr 3, full=1, err_overflow=1, ADDI not written, cmd_ready stays 0.
- cmd_kind=12 → err_illegal=1, no mem_we, count unchanged. Assert rst during LI2 → mem_we=0 next cycle, count=0, all flags cleared.
